// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage: selects register IDs, reads valA/valB
// combinationally from a 15x64 register file, and commits valE/valM with a sticky halt.
module decode_writeback #(
  parameter int                 WIDTH    = 64,
  parameter logic [WIDTH-1:0]   RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             inst_valid,
  input  logic             imem_er,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             wb_en,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             halted,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam int         NUM_REGS = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             halt_now;
  logic             commit;

  // Register ID selection; unknown or reserved icodes fall through to "none".
  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    srcA = REG_NONE;
    srcB = REG_NONE;
    dstE = REG_NONE;
    dstM = REG_NONE;
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : REG_NONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_RET: begin
        srcA = REG_RSP;
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_POPQ: begin
        srcA = REG_RSP;
        srcB = REG_RSP;
        dstE = REG_RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  assign valA     = (srcA     == REG_NONE) ? '0 : regs[srcA];
  assign valB     = (srcB     == REG_NONE) ? '0 : regs[srcB];
  assign dbg_data = (dbg_addr == REG_NONE) ? '0 : regs[dbg_addr];

  assign halt_now = (icode == I_HALT) || !inst_valid || imem_er;
  assign commit   = wb_en && !halted;

  // NOTE: the register file is reset explicitly because %rsp has a non-zero
  // architectural reset value and halt/restart must see a clean machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : '0;
      end
      halted <= 1'b0;
    end else if (commit) begin
      if (halt_now) begin
        halted <= 1'b1;
      end else begin
        // NOTE: non-blocking writes resolve in program order, so the valM
        // write below overrides valE when both target the same register.
        if (dstE != REG_NONE) regs[dstE] <= valE;
        if (dstM != REG_NONE) regs[dstM] <= valM;
      end
    end
  end

endmodule
